// File: rtl/vga_arb_pkg.sv
// Shared types and defaults for the VGA write-port arbiter.
// Optional feature macro used by the arbiter: ARB_WATCHDOG_EN.
package vga_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int N_REQ_DEF     = 4;
  localparam int X_W_DEF       = 8;
  localparam int Y_W_DEF       = 7;
  localparam int COL_W_DEF     = 3;
  localparam int SCREEN_W_DEF  = 160;
  localparam int SCREEN_H_DEF  = 120;
  localparam int MAX_BURST_DEF = 19200;

  // A pixel is drawn only when both coordinates fall inside the visible area.
  function automatic logic on_screen(input int x, input int y, input int w, input int h);
    return (x < w) && (y < h);
  endfunction

endpackage

// File: rtl/vga_write_arbiter_if.sv
// Bundle of pixel-writer request buses and the adapter-side write port.
// master: the writers / adapter side; slave: the arbiter.
interface vga_write_arbiter_if
  import vga_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int X_W   = X_W_DEF,
  parameter int Y_W   = Y_W_DEF,
  parameter int COL_W = COL_W_DEF
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ*X_W-1:0]   req_x;
  logic [N_REQ*Y_W-1:0]   req_y;
  logic [N_REQ*COL_W-1:0] req_colour;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic [X_W-1:0]         vga_x;
  logic [Y_W-1:0]         vga_y;
  logic [COL_W-1:0]       vga_colour;
  logic                   vga_plot;
  logic                   burst_timeout;

  modport master (
    output req, req_last, req_x, req_y, req_colour,
    input  gnt, busy, vga_x, vga_y, vga_colour, vga_plot, burst_timeout
  );

  modport slave (
    input  req, req_last, req_x, req_y, req_colour,
    output gnt, busy, vga_x, vga_y, vga_colour, vga_plot, burst_timeout
  );

endinterface

// File: rtl/vga_write_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above the
// pointer, wrapping around; returns it one-hot plus a valid flag.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic             o_valid
);

  logic [PTR_W-1:0] w_idx;

  // Scan from the pointer upward; the first hit wins and blocks later ones.
  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = PTR_W'((int'(i_ptr) + k) % N_REQ);
      if (!o_valid && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        o_valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter sharing the VGA adapter write port among pixel writers.
// Bursts are granted whole; off-screen pixels are accepted but not plotted.
// Define ARB_WATCHDOG_EN to add a burst-length watchdog that forces a release.
module vga_write_arbiter
  import vga_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int X_W       = X_W_DEF,
  parameter int Y_W       = Y_W_DEF,
  parameter int COL_W     = COL_W_DEF,
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic               clk,
  input  logic               reset,
  vga_write_arbiter_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [PTR_W-1:0] r_gidx, w_gidx_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic [N_REQ-1:0] w_pick;
  logic             w_pick_vld;
  logic [PTR_W-1:0] w_pick_idx;

  logic [X_W-1:0]   w_x;
  logic [Y_W-1:0]   w_y;
  logic [COL_W-1:0] w_col;
  logic             w_acc, w_acc_last, w_wd_fire, w_release;
  logic             w_vld_nxt, w_to_nxt;

  logic [X_W-1:0]   r_vga_x_p1;
  logic [Y_W-1:0]   r_vga_y_p1;
  logic [COL_W-1:0] r_vga_col_p1;
  logic             r_vld_p1;
  logic             r_timeout_p1;

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_pick  (w_pick),
    .o_valid (w_pick_vld)
  );

  // Convert the picker's one-hot choice to an index for slice selection.
  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick[i]) w_pick_idx = PTR_W'(i);
    end
  end

  assign w_x   = bus.req_x[r_gidx*X_W +: X_W];
  assign w_y   = bus.req_y[r_gidx*Y_W +: Y_W];
  assign w_col = bus.req_colour[r_gidx*COL_W +: COL_W];

  assign w_acc      = (r_state == BURST) && bus.req[r_gidx];
  assign w_acc_last = w_acc && bus.req_last[r_gidx];

`ifdef ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] r_wd_cnt;

  // Burst-length counter: zero on the first granted cycle, +1 per BURST cycle.
  always_ff @(posedge clk) begin
    if (!reset)                r_wd_cnt <= '0;
    else if (r_state == IDLE)  r_wd_cnt <= '0;
    else                       r_wd_cnt <= r_wd_cnt + CNT_W'(1);
  end

  assign w_wd_fire = (r_state == BURST) && (r_wd_cnt == CNT_W'(MAX_BURST - 1)) && !w_acc_last;
`else
  wire w_unused_max_burst = ^MAX_BURST;
  assign w_wd_fire = 1'b0;
`endif

  assign w_release = (r_state == BURST) && (w_acc_last || w_wd_fire);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: grant on any request, release on last pixel or watchdog.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_vld) w_state_nxt = BURST;
      BURST:   if (w_release)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode: next grant, pointer, plot strobe and timeout pulse.
  always_comb begin
    w_gnt_nxt  = r_gnt;
    w_gidx_nxt = r_gidx;
    w_ptr_nxt  = r_ptr;
    w_vld_nxt  = 1'b0;
    w_to_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_gnt_nxt  = w_pick;
          w_gidx_nxt = w_pick_idx;
        end
      end
      BURST: begin
        w_vld_nxt = w_acc && on_screen(int'(w_x), int'(w_y), SCREEN_W, SCREEN_H);
        if (w_release) begin
          w_gnt_nxt = '0;
          w_ptr_nxt = PTR_W'((int'(r_gidx) + 1) % N_REQ);
          w_to_nxt  = w_wd_fire;
        end
      end
      default: w_gnt_nxt = '0;
    endcase
  end

  // Control registers: grant, round-robin pointer, plot strobe, timeout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_gnt        <= '0;
      r_gidx       <= '0;
      r_ptr        <= '0;
      r_vld_p1     <= 1'b0;
      r_timeout_p1 <= 1'b0;
    end else begin
      r_gnt        <= w_gnt_nxt;
      r_gidx       <= w_gidx_nxt;
      r_ptr        <= w_ptr_nxt;
      r_vld_p1     <= w_vld_nxt;
      r_timeout_p1 <= w_to_nxt;
    end
  end

  // ---- stage p1: adapter pixel register, loaded only for drawn pixels ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vga_x_p1   <= '0;
      r_vga_y_p1   <= '0;
      r_vga_col_p1 <= '0;
    end else if (w_vld_nxt) begin
      r_vga_x_p1   <= w_x;
      r_vga_y_p1   <= w_y;
      r_vga_col_p1 <= w_col;
    end
  end

  assign bus.gnt           = r_gnt;
  assign bus.busy          = (r_state == BURST);
  assign bus.vga_x         = r_vga_x_p1;
  assign bus.vga_y         = r_vga_y_p1;
  assign bus.vga_colour    = r_vga_col_p1;
  assign bus.vga_plot      = r_vld_p1;
  assign bus.burst_timeout = r_timeout_p1;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: queue-driven pixel writers, a cycle-level
// reference model checked every cycle, plus literal per-scenario expectations.
`timescale 1ns/1ps
module tb_vga_write_arbiter;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
`ifdef ARB_WATCHDOG_EN
  localparam int MB = 8;
  localparam bit WD = 1'b1;
`else
  localparam int MB = 19200;
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vga_write_arbiter_if #(.N_REQ(N), .X_W(XW), .Y_W(YW), .COL_W(CW)) bus ();

  vga_write_arbiter #(
    .N_REQ(N), .X_W(XW), .Y_W(YW), .COL_W(CW),
    .SCREEN_W(160), .SCREEN_H(120), .MAX_BURST(MB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit            gap;
    bit            lst;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
  } pix_t;

  pix_t         q [N][$];
  logic [N-1:0] drv_gap;
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_fail = 0;

  // directed expectations for the current cycle (written by stimulus only)
  string         d_tag = "";
  bit            d_gnt_en = 0, d_plot_en = 0, d_busy_en = 0, d_pix_en = 0, d_to_en = 0;
  logic [N-1:0]  d_gnt;
  logic          d_plot, d_busy, d_to;
  logic [XW-1:0] d_x;
  logic [YW-1:0] d_y;
  logic [CW-1:0] d_c;

  // ---------------- reference model ----------------
  bit            m_valid = 0;
  int            m_g = -1;
  int            m_ptr = 0;
  int            m_cnt = 0;
  logic [XW-1:0] m_x;
  logic [YW-1:0] m_y;
  logic [CW-1:0] m_c;
  logic          m_plot, m_to;

  function automatic int first_req(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_valid <= 1; m_g <= -1; m_ptr <= 0; m_cnt <= 0;
      m_x <= '0; m_y <= '0; m_c <= '0; m_plot <= 0; m_to <= 0;
    end else if (m_g < 0) begin
      m_plot <= 0; m_to <= 0; m_cnt <= 0;
      m_g <= first_req(bus.req, m_ptr);
    end else begin
      if (bus.req[m_g] && bus.req_x[m_g*XW +: XW] < 160 && bus.req_y[m_g*YW +: YW] < 120) begin
        m_plot <= 1;
        m_x <= bus.req_x[m_g*XW +: XW];
        m_y <= bus.req_y[m_g*YW +: YW];
        m_c <= bus.req_colour[m_g*CW +: CW];
      end else begin
        m_plot <= 0;
      end
      if ((bus.req[m_g] && bus.req_last[m_g]) || (WD && m_cnt == MB - 1)) begin
        m_g   <= -1;
        m_ptr <= (m_g + 1) % N;
        m_to  <= WD && (m_cnt == MB - 1) && !(bus.req[m_g] && bus.req_last[m_g]);
      end else begin
        m_to <= 0;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  // ---------------- compare process ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model gnt",   32'(bus.gnt), (m_g < 0) ? 32'd0 : (32'd1 << m_g));
      chk("model busy",  32'(bus.busy), (m_g < 0) ? 32'd0 : 32'd1);
      chk("model plot",  32'(bus.vga_plot), 32'(m_plot));
      chk("model tmo",   32'(bus.burst_timeout), 32'(m_to));
      chk("model x",     32'(bus.vga_x), 32'(m_x));
      chk("model y",     32'(bus.vga_y), 32'(m_y));
      chk("model col",   32'(bus.vga_colour), 32'(m_c));
    end
    if (d_gnt_en)  chk({d_tag, " gnt"},  32'(bus.gnt), 32'(d_gnt));
    if (d_plot_en) chk({d_tag, " plot"}, 32'(bus.vga_plot), 32'(d_plot));
    if (d_busy_en) chk({d_tag, " busy"}, 32'(bus.busy), 32'(d_busy));
    if (d_to_en)   chk({d_tag, " tmo"},  32'(bus.burst_timeout), 32'(d_to));
    if (d_pix_en) begin
      chk({d_tag, " x"},   32'(bus.vga_x), 32'(d_x));
      chk({d_tag, " y"},   32'(bus.vga_y), 32'(d_y));
      chk({d_tag, " col"}, 32'(bus.vga_colour), 32'(d_c));
    end
  end

  // ---------------- writer drivers ----------------
  task automatic push(input int i, input bit gap, input bit lst, input int x, input int y, input int c);
    pix_t p;
    p.gap = gap; p.lst = lst; p.x = XW'(x); p.y = YW'(y); p.c = CW'(c);
    q[i].push_back(p);
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) q[i].delete();
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      drv_gap[i] = 1'b0;
      if (q[i].size() == 0) begin
        bus.req[i] = 1'b0; bus.req_last[i] = 1'b0;
      end else if (q[i][0].gap) begin
        bus.req[i] = 1'b0; bus.req_last[i] = 1'b0;
        drv_gap[i] = bus.gnt[i];
      end else begin
        bus.req[i]               = 1'b1;
        bus.req_last[i]          = q[i][0].lst;
        bus.req_x[i*XW +: XW]    = q[i][0].x;
        bus.req_y[i*YW +: YW]    = q[i][0].y;
        bus.req_colour[i*CW +: CW] = q[i][0].c;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] acc;
    acc = bus.req & bus.gnt;
    @(posedge clk);
    #1;
    d_gnt_en = 0; d_plot_en = 0; d_busy_en = 0; d_pix_en = 0; d_to_en = 0;
    for (int i = 0; i < N; i++) begin
      if ((acc[i] || drv_gap[i]) && q[i].size() > 0) void'(q[i].pop_front());
    end
    drive();
    cyc++;
  endtask

  task automatic ex_gnt(input string t, input logic [N-1:0] v);
    d_tag = t; d_gnt_en = 1; d_gnt = v;
  endtask
  task automatic ex_busy(input string t, input logic v);
    d_tag = t; d_busy_en = 1; d_busy = v;
  endtask
  task automatic ex_to(input string t, input logic v);
    d_tag = t; d_to_en = 1; d_to = v;
  endtask
  task automatic ex_plot(input string t, input logic v);
    d_tag = t; d_plot_en = 1; d_plot = v;
  endtask
  task automatic ex_pix(input string t, input logic p, input int x, input int y, input int c);
    d_tag = t; d_plot_en = 1; d_plot = p;
    d_pix_en = 1; d_x = XW'(x); d_y = YW'(y); d_c = CW'(c);
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  logic [N-1:0] exp_rr [5];

  initial begin
    bus.req = '0; bus.req_last = '0; bus.req_x = '0; bus.req_y = '0; bus.req_colour = '0;
    drv_gap = '0;

    // reset held with every writer requesting
    reset = 1'b0;
    for (int i = 0; i < N; i++) push(i, 0, 1, 50 + i, 50, i);
    drive();
    step(); step();
    ex_gnt("reset", '0); ex_plot("reset", 0); ex_busy("reset", 0); ex_to("reset", 0);
    flush(); drive();
    reset = 1'b1;
    step(); step();

    // single three-pixel burst from requester 2
    push(2, 0, 0, 10, 5, 1); push(2, 0, 0, 11, 5, 2); push(2, 0, 1, 12, 5, 3);
    drive();
    step(); ex_gnt("single", 4'b0100);
    step(); ex_pix("single p0", 1, 10, 5, 1);
    step(); ex_pix("single p1", 1, 11, 5, 2);
    step(); ex_pix("single p2", 1, 12, 5, 3);
    step(); ex_busy("single", 0);
    step();

    // round robin from a freshly reset pointer
    reset = 1'b0; step(); reset = 1'b1; step();
    push(0, 0, 1, 20, 10, 4); push(0, 0, 1, 24, 10, 5);
    push(1, 0, 1, 21, 10, 6); push(2, 0, 1, 22, 10, 7); push(3, 0, 1, 23, 10, 1);
    drive();
    exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
    exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
    for (int s = 1; s <= 9; s++) begin
      step();
      if (s % 2 == 1) ex_gnt("rr", exp_rr[s / 2]);
      else            ex_busy("rr bubble", 0);
    end
    step(); step();

    // gap and clipping on requester 1
    push(1, 0, 0, 159, 119, 6); push(1, 1, 0, 0, 0, 0);
    push(1, 0, 0, 160, 0, 7);   push(1, 0, 0, 0, 120, 1); push(1, 0, 1, 5, 5, 2);
    drive();
    step(); ex_gnt("clip", 4'b0010);
    step(); ex_pix("clip edge", 1, 159, 119, 6);
    step(); ex_plot("clip gap", 0); ex_gnt("clip gap", 4'b0010);
    step(); ex_pix("clip x", 0, 159, 119, 6);
    step(); ex_plot("clip y", 0); ex_gnt("clip y", 4'b0010);
    step(); ex_pix("clip last", 1, 5, 5, 2);
    step(); ex_busy("clip end", 0);
    step();

    // reset during the second pixel of a burst
    push(0, 0, 0, 30, 3, 1); push(0, 0, 0, 31, 3, 2); push(0, 0, 1, 32, 3, 3);
    drive();
    step(); ex_gnt("mrst", 4'b0001);
    step(); ex_pix("mrst p0", 1, 30, 3, 1);
    reset = 1'b0;
    step(); ex_plot("mrst", 0); ex_gnt("mrst", '0);
    flush(); drive();
    reset = 1'b1;
    step();
    push(1, 0, 1, 40, 4, 4); push(3, 0, 1, 43, 4, 5);
    drive();
    step(); ex_gnt("mrst ptr", 4'b0010);
    for (int s = 0; s < 6; s++) step();

`ifdef ARB_WATCHDOG_EN
    // move the pointer to 3, then hold requester 3 without a last pixel
    push(2, 0, 1, 60, 6, 1);
    drive();
    for (int s = 0; s < 4; s++) step();
    for (int k = 0; k < 12; k++) push(3, 0, 0, 70 + k, 7, k);
    push(0, 0, 1, 90, 9, 3);
    drive();
    step(); ex_gnt("wd", 4'b1000);
    for (int s = 2; s <= 8; s++) begin
      step(); ex_gnt("wd hold", 4'b1000); ex_to("wd hold", 0);
    end
    step(); ex_gnt("wd fire", '0); ex_to("wd fire", 1); ex_pix("wd final", 1, 77, 7, 7);
    q[3].delete(); drive();
    step(); ex_gnt("wd next", 4'b0001); ex_to("wd next", 0);
    for (int s = 0; s < 4; s++) step();
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
